// File: rtl/cnn_batch_norm_bias_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_batch_norm_bias_ctrl
//
// Loads a stream of batch-norm bias words into OUTPUT_BRAM_NUM bias banks
// (word n goes to bank n mod OUTPUT_BRAM_NUM at index n). Once the load is
// complete, it serves fetch requests that read one bias per bank for the
// channels base..base+OUTPUT_BRAM_NUM-1.
//
// Optional feature: define CNN_BN_BIAS_ERR_CHECK_EN to build the sticky
// protocol/range error flag. Without it, o_error is tied to 0.
//
// Ports
//   i_clock            : clock, all logic on the rising edge
//   i_reset            : asynchronous active-low reset
//   i_start            : begin a bias load (accepted in IDLE or READY)
//   i_bias_size        : number of bias words, sampled on accepted i_start
//   i_data_valid/i_data: bias word stream, o_data_ready is its ready
//   i_bram_reset_busy  : OR of the bank reset-busy flags
//   o_bram_enable      : bank enable (write or read cycle)
//   o_wenable          : per-bank write enable, one-hot during a write
//   o_bram_data        : write data broadcast to all banks
//   o_data_point       : per-bank bias index (bank address = index / banks)
//   i_fetch            : request biases for channels starting at i_channel_base
//   o_busy             : high while waiting for bank reset, loading or fetching
//   o_load_done        : high once a complete load has finished
//   o_bias_valid       : one-cycle pulse when fetched bank data is valid
//   o_error            : sticky error flag (optional build)
// -----------------------------------------------------------------------------
module cnn_batch_norm_bias_ctrl #(
    parameter int OUTPUT_BRAM_NUM       = 4,
    parameter int DATA_WIDTH            = 32,
    parameter int BATCH_NORM_BIAS_WIDTH = 8,
    parameter int BRAM_READ_LATENCY     = 2
) (
    input  logic                                                  i_clock,
    input  logic                                                  i_reset,
    input  logic                                                  i_start,
    input  logic [BATCH_NORM_BIAS_WIDTH-1:0]                      i_bias_size,
    input  logic                                                  i_data_valid,
    input  logic [DATA_WIDTH-1:0]                                 i_data,
    output logic                                                  o_data_ready,
    input  logic                                                  i_bram_reset_busy,
    output logic                                                  o_bram_enable,
    output logic [OUTPUT_BRAM_NUM-1:0]                            o_wenable,
    output logic [DATA_WIDTH-1:0]                                 o_bram_data,
    output logic [OUTPUT_BRAM_NUM-1:0][BATCH_NORM_BIAS_WIDTH-1:0] o_data_point,
    input  logic                                                  i_fetch,
    input  logic [BATCH_NORM_BIAS_WIDTH-1:0]                      i_channel_base,
    output logic                                                  o_busy,
    output logic                                                  o_load_done,
    output logic                                                  o_bias_valid,
    output logic                                                  o_error
);

    localparam int BW     = BATCH_NORM_BIAS_WIDTH;
    localparam int BANK_W = (OUTPUT_BRAM_NUM > 1) ? $clog2(OUTPUT_BRAM_NUM) : 1;
    // Latency counter counts 0..BRAM_READ_LATENCY-1 inside FETCH.
    localparam int LAT_W  = (BRAM_READ_LATENCY > 1) ? $clog2(BRAM_READ_LATENCY) : 1;

    localparam logic [2:0] ST_WAIT_RST = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_READY    = 3'd3;
    localparam logic [2:0] ST_FETCH    = 3'd4;

    logic [2:0]                              state_reg;
    logic [BW-1:0]                           size_reg;
    logic [BW-1:0]                           word_cnt_reg;
    logic [BANK_W-1:0]                       bank_reg;
    logic [LAT_W-1:0]                        lat_cnt_reg;
    logic                                    bram_enable_reg;
    logic [OUTPUT_BRAM_NUM-1:0]              wenable_reg;
    logic [DATA_WIDTH-1:0]                   bram_data_reg;
    logic [OUTPUT_BRAM_NUM-1:0][BW-1:0]      data_point_reg;
    logic                                    load_done_reg;
    logic                                    bias_valid_reg;

    logic                                    start_ok;
    logic                                    fetch_ok;
    logic                                    xfer;
    logic                                    last_word;
    logic                                    lat_last;
    logic [OUTPUT_BRAM_NUM-1:0]              bank_onehot;
    logic [OUTPUT_BRAM_NUM-1:0][BW-1:0]      fetch_point;

    assign start_ok  = i_start && ((state_reg == ST_IDLE) || (state_reg == ST_READY));
    // i_start wins over i_fetch when both arrive in READY.
    assign fetch_ok  = i_fetch && !i_start && (state_reg == ST_READY);
    assign xfer      = (state_reg == ST_LOAD) && i_data_valid;
    assign last_word = (word_cnt_reg == (size_reg - BW'(1)));
    assign lat_last  = (lat_cnt_reg == LAT_W'(BRAM_READ_LATENCY - 1));

    // Bank pointer is kept separately from the word counter so no modulo
    // is needed for non power-of-two bank counts.
    generate
        for (genvar gi = 0; gi < OUTPUT_BRAM_NUM; gi++) begin : g_lane
            assign bank_onehot[gi] = (bank_reg == BANK_W'(gi));
            assign fetch_point[gi] = i_channel_base + BW'(gi);  // wraps mod 2^BW
        end
    endgenerate

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg       <= ST_WAIT_RST;
            size_reg        <= '0;
            word_cnt_reg    <= '0;
            bank_reg        <= '0;
            lat_cnt_reg     <= '0;
            bram_enable_reg <= 1'b0;
            wenable_reg     <= '0;
            bram_data_reg   <= '0;
            data_point_reg  <= '0;
            load_done_reg   <= 1'b0;
            bias_valid_reg  <= 1'b0;
        end else begin
            // Enables and the valid pulse are single-cycle by default.
            bram_enable_reg <= 1'b0;
            wenable_reg     <= '0;
            bias_valid_reg  <= 1'b0;

            if (state_reg == ST_WAIT_RST) begin
                if (!i_bram_reset_busy) begin
                    state_reg <= ST_IDLE;
                end
            end

            if (start_ok) begin
                size_reg     <= i_bias_size;
                word_cnt_reg <= '0;
                bank_reg     <= '0;
                if (i_bias_size == '0) begin
                    state_reg     <= ST_READY;
                    load_done_reg <= 1'b1;
                end else begin
                    state_reg     <= ST_LOAD;
                    load_done_reg <= 1'b0;
                end
            end else if (fetch_ok) begin
                data_point_reg  <= fetch_point;
                bram_enable_reg <= 1'b1;
                lat_cnt_reg     <= '0;
                state_reg       <= ST_FETCH;
            end

            if (xfer) begin
                bram_enable_reg <= 1'b1;
                wenable_reg     <= bank_onehot;
                bram_data_reg   <= i_data;
                for (int i = 0; i < OUTPUT_BRAM_NUM; i++) begin
                    data_point_reg[i] <= word_cnt_reg;
                end
                word_cnt_reg <= word_cnt_reg + BW'(1);
                bank_reg     <= (bank_reg == BANK_W'(OUTPUT_BRAM_NUM - 1)) ?
                                '0 : bank_reg + BANK_W'(1);
                if (last_word) begin
                    state_reg     <= ST_READY;
                    load_done_reg <= 1'b1;
                end
            end

            // Read cycle is the first FETCH cycle; valid lands exactly
            // BRAM_READ_LATENCY cycles later.
            if (state_reg == ST_FETCH) begin
                if (lat_last) begin
                    bias_valid_reg <= 1'b1;
                    state_reg      <= ST_READY;
                end else begin
                    lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                end
            end
        end
    end

`ifdef CNN_BN_BIAS_ERR_CHECK_EN
    logic error_reg;
    logic range_bad;
    logic err_event;

    // Widened arithmetic so base + banks - 1 cannot wrap before comparing.
    assign range_bad = ((int'(i_channel_base) + OUTPUT_BRAM_NUM - 1) >= int'(size_reg));
    assign err_event = (i_start && !start_ok)
                     || (i_fetch && (state_reg != ST_READY))
                     || (fetch_ok && range_bad);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            error_reg <= 1'b0;
        end else if (err_event) begin
            error_reg <= 1'b1;
        end
    end

    assign o_error = error_reg;
`else
    assign o_error = 1'b0;
`endif

    assign o_data_ready  = (state_reg == ST_LOAD);
    assign o_busy        = (state_reg == ST_WAIT_RST) || (state_reg == ST_LOAD) ||
                           (state_reg == ST_FETCH);
    assign o_bram_enable = bram_enable_reg;
    assign o_wenable     = wenable_reg;
    assign o_bram_data   = bram_data_reg;
    assign o_data_point  = data_point_reg;
    assign o_load_done   = load_done_reg;
    assign o_bias_valid  = bias_valid_reg;

endmodule
